// File: rtl/cv32e40x_aes_dom_pkg.sv
// Shared types and constants for the masked (DOM) SAES32 issue sequencer.
//   saes_op_t    : {decrypt, middle_round} operation encoding
//   seq_state_e  : sequencer FSM states
//   LFSR_TAPS    : Galois feedback mask of the 64-bit mask LFSR
//   DEFAULT_SEED : reset / fallback seed of the mask LFSR
//   lfsr_step    : one Galois LFSR step (right shift, taps on bit 0 out)
package cv32e40x_aes_dom_pkg;

  typedef struct packed {
    logic decrypt;
    logic middle_round;
  } saes_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam logic [63:0] LFSR_TAPS    = 64'hD800000000000000;
  localparam logic [63:0] DEFAULT_SEED = 64'h9E3779B97F4A7C15;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

endpackage

// File: rtl/cv32e40x_aes_dom_lfsr.sv
// 64-bit Galois mask LFSR supplying fresh randomness to the DOM S-box.
//   i_clk, i_reset : clock, synchronous active-high reset (loads SEED)
//   i_load         : load i_seed this cycle (a zero seed loads SEED instead)
//   i_seed         : new seed value
//   i_en           : advance one step this cycle
//   o_rnd          : low RND_WIDTH bits of the LFSR state
module cv32e40x_aes_dom_lfsr
  import cv32e40x_aes_dom_pkg::*;
#(
  parameter int unsigned RND_WIDTH = 36,
  parameter logic [63:0] SEED      = DEFAULT_SEED
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic [63:0]          i_seed,
  input  logic                 i_en,
  output logic [RND_WIDTH-1:0] o_rnd
);

  logic [63:0] r_state;
  logic [63:0] w_seed;

  // An all-zero state would lock the LFSR up, so zero seeds fall back to SEED.
  assign w_seed = (i_seed == 64'h0) ? SEED : i_seed;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= w_seed;
    end else if (i_en) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_rnd = r_state[RND_WIDTH-1:0];

endmodule

// File: rtl/cv32e40x_aes_dom_sequencer.sv
// Issue/sequencing stage for the masked (DOM) SAES32 functional unit.
// Accepts one operation from EX, holds operands stable for SBOX_LATENCY cycles while the
// DOM S-box settles, feeds it fresh randomness every cycle and returns the captured result
// through a valid/ready handshake.
//   i_clk, i_reset                   : clock, synchronous active-high reset
//   i_in_valid / o_in_ready          : operation handshake from EX
//   i_in_op, i_in_rs1..3, i_in_bs    : operation, round key, state shares, byte select
//   i_flush                          : kill any in-flight operation
//   i_reseed_valid, i_reseed_data    : load a new mask LFSR seed (IDLE only)
//   o_fu_valid, o_fu_op, o_fu_rs1..3,
//   o_fu_bs, o_fu_rnd                : operands and randomness to the FU (zero when idle)
//   i_fu_rd                          : FU result (combined shares)
//   o_out_valid / i_out_ready, o_out_rd : result handshake (o_out_rd zero when not valid)
//   o_busy                           : sequencer not idle
module cv32e40x_aes_dom_sequencer
  import cv32e40x_aes_dom_pkg::*;
#(
  parameter int unsigned SBOX_LATENCY = 4,
  parameter int unsigned RND_WIDTH    = 36,
  parameter logic [63:0] LFSR_SEED    = DEFAULT_SEED
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [1:0]           i_in_op,
  input  logic [31:0]          i_in_rs1,
  input  logic [31:0]          i_in_rs2,
  input  logic [31:0]          i_in_rs3,
  input  logic [1:0]           i_in_bs,
  input  logic                 i_flush,
  input  logic                 i_reseed_valid,
  input  logic [63:0]          i_reseed_data,
  output logic                 o_fu_valid,
  output logic [1:0]           o_fu_op,
  output logic [31:0]          o_fu_rs1,
  output logic [31:0]          o_fu_rs2,
  output logic [31:0]          o_fu_rs3,
  output logic [1:0]           o_fu_bs,
  output logic [RND_WIDTH-1:0] o_fu_rnd,
  input  logic [31:0]          i_fu_rd,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [31:0]          o_out_rd,
  output logic                 o_busy
);

  localparam int unsigned    CNT_W    = $clog2(SBOX_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SBOX_LATENCY - 1);

  seq_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  saes_op_t         r_op;
  logic [31:0]      r_rs1;
  logic [31:0]      r_rs2;
  logic [31:0]      r_rs3;
  logic [1:0]       r_bs;
  logic [31:0]      r_result;

  logic                 w_accept;
  logic                 w_run;
  logic                 w_reseed;
  logic [RND_WIDTH-1:0] w_rnd;

  assign w_run      = (r_state == RUN);
  assign o_in_ready = (r_state == IDLE) | ((r_state == DONE) & i_out_ready);
  // A flush in the same cycle as an issue wins: the op is dropped.
  assign w_accept   = i_in_valid & o_in_ready & ~i_flush;
  assign w_reseed   = (r_state == IDLE) & i_reseed_valid & ~i_flush;

  cv32e40x_aes_dom_lfsr #(
    .RND_WIDTH (RND_WIDTH),
    .SEED      (LFSR_SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_reseed),
    .i_seed  (i_reseed_data),
    .i_en    (w_run),
    .o_rnd   (w_rnd)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rs3    <= '0;
      r_bs     <= '0;
      r_result <= '0;
    end else if (i_flush) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rs3    <= '0;
      r_bs     <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      // Covers both a fresh issue from IDLE and back-to-back issue out of DONE.
      r_state <= RUN;
      r_cnt   <= CNT_LOAD;
      r_op    <= saes_op_t'(i_in_op);
      r_rs1   <= i_in_rs1;
      r_rs2   <= i_in_rs2;
      r_rs3   <= i_in_rs3;
      r_bs    <= i_in_bs;
    end else begin
      case (r_state)
        RUN: begin
          if (r_cnt == '0) begin
            r_result <= i_fu_rd;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          // Result consumed with no follow-up op: scrub secrets on the way to IDLE.
          if (i_out_ready) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rs3    <= '0;
            r_bs     <= '0;
            r_result <= '0;
          end
        end
        IDLE: ;
        default: begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_op     <= '0;
          r_rs1    <= '0;
          r_rs2    <= '0;
          r_rs3    <= '0;
          r_bs     <= '0;
          r_result <= '0;
        end
      endcase
    end
  end

  // Operand and randomness buses are zero outside RUN so shares never leak while idle/done.
  assign o_fu_valid  = w_run;
  assign o_fu_op     = w_run ? r_op  : '0;
  assign o_fu_rs1    = w_run ? r_rs1 : '0;
  assign o_fu_rs2    = w_run ? r_rs2 : '0;
  assign o_fu_rs3    = w_run ? r_rs3 : '0;
  assign o_fu_bs     = w_run ? r_bs  : '0;
  assign o_fu_rnd    = w_run ? w_rnd : '0;
  assign o_out_valid = (r_state == DONE);
  assign o_out_rd    = o_out_valid ? r_result : '0;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cv32e40x_aes_dom_sequencer.sv
// Self-checking bench for cv32e40x_aes_dom_sequencer: directed scenarios plus a randomized
// run, with an AES S-box + XOR functional-unit model and a reference mask LFSR.
module tb_cv32e40x_aes_dom_sequencer;

  localparam int unsigned L    = 4;
  localparam int unsigned RW   = 36;
  localparam logic [63:0] SEED = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] TAPS = 64'hD800000000000000;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [31:0]   in_rs1, in_rs2, in_rs3;
  logic [1:0]    in_bs;
  logic          flush;
  logic          reseed_valid;
  logic [63:0]   reseed_data;
  logic          fu_valid;
  logic [1:0]    fu_op;
  logic [31:0]   fu_rs1, fu_rs2, fu_rs3;
  logic [1:0]    fu_bs;
  logic [RW-1:0] fu_rnd;
  logic [31:0]   fu_rd;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_rd;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [63:0] m_lfsr;
  logic [1:0]  m_op;
  logic [31:0] m_rs1, m_rs2, m_rs3, m_exp;
  logic [1:0]  m_bs;

  cv32e40x_aes_dom_sequencer #(
    .SBOX_LATENCY (L),
    .RND_WIDTH    (RW),
    .LFSR_SEED    (SEED)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_op        (in_op),
    .i_in_rs1       (in_rs1),
    .i_in_rs2       (in_rs2),
    .i_in_rs3       (in_rs3),
    .i_in_bs        (in_bs),
    .i_flush        (flush),
    .i_reseed_valid (reseed_valid),
    .i_reseed_data  (reseed_data),
    .o_fu_valid     (fu_valid),
    .o_fu_op        (fu_op),
    .o_fu_rs1       (fu_rs1),
    .o_fu_rs2       (fu_rs2),
    .o_fu_rs3       (fu_rs3),
    .o_fu_bs        (fu_bs),
    .o_fu_rnd       (fu_rnd),
    .i_fu_rd        (fu_rd),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_rd       (out_rd),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1B;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // AES S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] fu_fn(input logic [31:0] k, input logic [31:0] a,
                                        input logic [31:0] b, input logic [1:0] bs);
    logic [31:0] st;
    st = (a ^ b) >> (8 * bs);
    return k ^ {24'h0, sbox(st[7:0])};
  endfunction

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 64'h0);
  endfunction

  // FU stand-in: garbage unless operands are being presented.
  always_comb begin
    fu_rd = 32'hDEADBEEF;
    if (fu_valid) fu_rd = fu_fn(fu_rs1, fu_rs2, fu_rs3, fu_bs);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [1:0] bs);
    int budget;
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rs3 = c; in_bs = bs;
    #1;
    budget = 50;
    while (!in_ready && budget > 0) begin
      tick();
      #1;
      budget--;
    end
    if (budget == 0) chk("issue_timeout", 64'(in_ready), 64'd1);
    m_op = op; m_rs1 = a; m_rs2 = b; m_rs3 = c; m_bs = bs;
    m_exp = fu_fn(a, b, c, bs);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_op = 2'($urandom); in_rs1 = $urandom; in_rs2 = $urandom; in_rs3 = $urandom;
    in_bs = 2'($urandom);
  endtask

  task automatic check_run(input bit reseed_mid);
    logic [RW-1:0] seen [L];
    for (int k = 0; k < L; k++) begin
      if (reseed_mid && k == 1) begin
        reseed_valid = 1'b1;
        reseed_data  = 64'h1;
      end
      #1;
      chk("run_fu_valid", 64'(fu_valid), 64'd1);
      chk("run_fu_op", 64'(fu_op), 64'(m_op));
      chk("run_fu_rs1", 64'(fu_rs1), 64'(m_rs1));
      chk("run_fu_rs2", 64'(fu_rs2), 64'(m_rs2));
      chk("run_fu_rs3", 64'(fu_rs3), 64'(m_rs3));
      chk("run_fu_bs", 64'(fu_bs), 64'(m_bs));
      chk("run_fu_rnd", 64'(fu_rnd), 64'(m_lfsr[RW-1:0]));
      chk("run_out_valid", 64'(out_valid), 64'd0);
      chk("run_in_ready", 64'(in_ready), 64'd0);
      chk("run_busy", 64'(busy), 64'd1);
      seen[k] = fu_rnd;
      m_lfsr = lfsr_next(m_lfsr);
      tick();
      reseed_valid = 1'b0;
    end
    for (int i = 0; i < L; i++) begin
      for (int j = i + 1; j < L; j++) begin
        chk("run_rnd_distinct", 64'(seen[i] != seen[j]), 64'd1);
      end
    end
  endtask

  // Holds out_ready low for 'stall' DONE cycles, then raises it without taking the edge.
  task automatic done_wait(input int stall);
    out_ready = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) out_ready = 1'b1;
      #1;
      chk("done_out_valid", 64'(out_valid), 64'd1);
      chk("done_out_rd", 64'(out_rd), 64'(m_exp));
      chk("done_in_ready", 64'(in_ready), 64'(s == stall));
      chk("done_busy", 64'(busy), 64'd1);
      chk("done_fu_valid", 64'(fu_valid), 64'd0);
      chk("done_fu_rs2", 64'(fu_rs2), 64'd0);
      chk("done_fu_rnd", 64'(fu_rnd), 64'd0);
      if (s < stall) tick();
    end
  endtask

  task automatic release_idle();
    tick();
    out_ready = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_out_rd", 64'(out_rd), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_fu_rs1", 64'(fu_rs1), 64'd0);
    chk("idle_fu_rnd", 64'(fu_rnd), 64'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
    in_bs = '0; flush = 1'b0; reseed_valid = 1'b0; reseed_data = '0; out_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fu_valid", 64'(fu_valid), 64'd0);
    chk("rst_fu_rnd", 64'(fu_rnd), 64'd0);
    reset = 1'b0;
    m_lfsr = SEED;
    tick();

    // Single encs, result at T+L+1, then a 10-cycle stall in DONE.
    issue(2'b00, 32'h0, 32'h00000053, 32'h0, 2'd0);
    check_run(1'b0);
    #1;
    chk("t1_out_rd_ed", 64'(out_rd), 64'h0000_00ED);
    done_wait(10);
    release_idle();

    // Back-to-back issue out of DONE.
    issue(2'b01, 32'h01020304, 32'hA5A5A5A5, 32'h3C3C3C3C, 2'd2);
    check_run(1'b0);
    done_wait(2);
    issue(2'b11, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0, 2'd3);
    check_run(1'b0);
    done_wait(0);
    release_idle();

    // Flush at T+2 kills the op.
    issue(2'b10, $urandom, $urandom, $urandom, 2'd1);
    #1;
    chk("fl_run1_fu_valid", 64'(fu_valid), 64'd1);
    m_lfsr = lfsr_next(m_lfsr);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_run2_fu_valid", 64'(fu_valid), 64'd1);
    m_lfsr = lfsr_next(m_lfsr);
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_busy", 64'(busy), 64'd0);
      chk("fl_fu_rs1", 64'(fu_rs1), 64'd0);
      chk("fl_fu_rs3", 64'(fu_rs3), 64'd0);
      tick();
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("fl_issue_dropped", 64'(busy), 64'd0);
    issue(2'b00, $urandom, $urandom, $urandom, 2'd0);
    check_run(1'b0);
    done_wait(1);
    release_idle();

    // Reseed with zero falls back to the default seed; reseed during RUN is ignored.
    reseed_valid = 1'b1;
    reseed_data  = 64'h0;
    tick();
    reseed_valid = 1'b0;
    m_lfsr = SEED;
    issue(2'b01, $urandom, $urandom, $urandom, 2'($urandom));
    check_run(1'b1);
    done_wait(0);
    release_idle();
    reseed_valid = 1'b1;
    reseed_data  = {$urandom, $urandom} | 64'h1;
    m_lfsr = reseed_data;
    tick();
    reseed_valid = 1'b0;
    issue(2'b10, $urandom, $urandom, $urandom, 2'($urandom));
    check_run(1'b0);
    done_wait(0);
    release_idle();

    // Reset while a result is waiting in DONE.
    issue(2'b11, $urandom, $urandom, $urandom, 2'($urandom));
    check_run(1'b0);
    #1;
    chk("rd_out_valid_pre", 64'(out_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rd_out_valid", 64'(out_valid), 64'd0);
    chk("rd_in_ready", 64'(in_ready), 64'd1);
    chk("rd_out_rd", 64'(out_rd), 64'd0);
    chk("rd_busy", 64'(busy), 64'd0);
    m_lfsr = SEED;
    tick();

    // Randomized sequence with random stalls and back-to-back issue.
    issue(2'($urandom), $urandom, $urandom, $urandom, 2'($urandom));
    check_run(1'b0);
    for (int i = 0; i < 12; i++) begin
      done_wait(int'($urandom_range(0, 3)));
      if (i < 11 && $urandom_range(0, 1) == 1) begin
        issue(2'($urandom), $urandom, $urandom, $urandom, 2'($urandom));
        check_run(1'b0);
      end else begin
        release_idle();
        if (i < 11) begin
          issue(2'($urandom), $urandom, $urandom, $urandom, 2'($urandom));
          check_run(1'b0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
